// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register: owns the fetch PC, drives a synchronous
// instruction ROM and holds a one-entry skid buffer so stalls never lose a response.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush_d,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus8_d,
  output logic        valid_d
);

  logic [31:0] pc_reg, pc_next;
  logic        req_reg, req_next;
  logic [31:0] rpc_reg, rpc_next;
  logic        skid_valid_reg, skid_valid_next;
  logic [31:0] skid_instr_reg, skid_instr_next;
  logic [31:0] skid_pc_reg, skid_pc_next;
  logic        valid_reg, valid_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pc_d_reg, pc_d_next;

  assign imem_req   = !stall && !reset;
  assign imem_addr  = pc_reg;
  assign pc_f       = pc_reg;
  assign instr_d    = instr_reg;
  assign pc_d       = pc_d_reg;
  assign valid_d    = valid_reg;
  assign pc_plus8_d = pc_d_reg + 32'd8;

  // PC: a redirect overrides a stall; the target's low bits are forced to word alignment.
  always_comb begin
    pc_next = pc_reg;
    if (branch_taken) begin
      pc_next = {branch_target[31:2], 2'b00};
    end else if (!stall) begin
      pc_next = pc_reg + 32'd4;
    end
  end

  // A request issued in the redirect cycle belongs to the wrong path, so it is not tracked.
  always_comb begin
    req_next = imem_req && !branch_taken;
    rpc_next = pc_reg;
  end

  always_comb begin
    valid_next      = valid_reg;
    instr_next      = instr_reg;
    pc_d_next       = pc_d_reg;
    skid_valid_next = skid_valid_reg;
    skid_instr_next = skid_instr_reg;
    skid_pc_next    = skid_pc_reg;
    if (branch_taken || flush_d) begin
      valid_next      = 1'b0;
      instr_next      = NOP_INSTR;
      skid_valid_next = 1'b0;
    end else if (stall) begin
      // Only one response can be pending here because stall suppresses new requests.
      if (req_reg) begin
        skid_valid_next = 1'b1;
        skid_instr_next = imem_rdata;
        skid_pc_next    = rpc_reg;
      end
    end else if (skid_valid_reg) begin
      valid_next      = 1'b1;
      instr_next      = skid_instr_reg;
      pc_d_next       = skid_pc_reg;
      skid_valid_next = 1'b0;
    end else if (req_reg) begin
      valid_next = 1'b1;
      instr_next = imem_rdata;
      pc_d_next  = rpc_reg;
    end else begin
      valid_next = 1'b0;
      instr_next = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg         <= RESET_PC;
      req_reg        <= 1'b0;
      rpc_reg        <= 32'h0000_0000;
      skid_valid_reg <= 1'b0;
      skid_instr_reg <= 32'h0000_0000;
      skid_pc_reg    <= 32'h0000_0000;
      valid_reg      <= 1'b0;
      instr_reg      <= NOP_INSTR;
      pc_d_reg       <= 32'h0000_0000;
    end else begin
      pc_reg         <= pc_next;
      req_reg        <= req_next;
      rpc_reg        <= rpc_next;
      skid_valid_reg <= skid_valid_next;
      skid_instr_reg <= skid_instr_next;
      skid_pc_reg    <= skid_pc_next;
      valid_reg      <= valid_next;
      instr_reg      <= instr_next;
      pc_d_reg       <= pc_d_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: ROM word at address a is a>>2, all expectations hand-computed.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        reset, stall, flush_d, branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata, pc_f, instr_d, pc_d, pc_plus8_d;
  logic        valid_d;

  logic        reset2, stall2, flush2, bt2;
  logic [31:0] target2;
  logic        imem_req2;
  logic [31:0] imem_addr2, imem_rdata2, pc_f2, instr_d2, pc_d2, pc_plus8_d2;
  logic        valid_d2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush_d(flush_d),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .pc_plus8_d(pc_plus8_d),
    .valid_d(valid_d)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(32'h0000_0000)) u_dut_wrap (
    .clk(clk), .reset(reset2), .stall(stall2), .flush_d(flush2),
    .branch_taken(bt2), .branch_target(target2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .pc_f(pc_f2), .instr_d(instr_d2), .pc_d(pc_d2), .pc_plus8_d(pc_plus8_d2),
    .valid_d(valid_d2)
  );

  // Synchronous ROMs; garbage when no request so stale data is never mistaken for a response.
  always @(posedge clk) begin
    imem_rdata  <= imem_req  ? (imem_addr  >> 2) : 32'hDEAD_BEEF;
    imem_rdata2 <= imem_req2 ? (imem_addr2 >> 2) : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] ins,
                          input logic [31:0] pcd);
    check({tag, ".valid"}, {31'd0, valid_d}, {31'd0, v});
    check({tag, ".instr"}, instr_d, ins);
    if (v) begin
      check({tag, ".pc_d"}, pc_d, pcd);
      check({tag, ".plus8"}, pc_plus8_d, pcd + 32'd8);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush_d = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    reset2 = 1'b1; stall2 = 1'b0; flush2 = 1'b0; bt2 = 1'b0; target2 = 32'h0;
    #1;
    check("rst.pc_f", pc_f, 32'h0);
    check("rst.req", {31'd0, imem_req}, 32'd0);
    check("rst.pc_d", pc_d, 32'h0);
    chk_ifid("rst", 1'b0, NOP, 32'h0);
    check("rst.plus8", pc_plus8_d, 32'h8);
    tick(); tick();

    // T1: free run
    reset = 1'b0; #1;
    check("t1.req", {31'd0, imem_req}, 32'd1);
    check("t1.addr", imem_addr, 32'h0);
    tick();
    check("t1.pc_f1", pc_f, 32'h4);
    chk_ifid("t1.e1", 1'b0, NOP, 32'h0);
    tick(); chk_ifid("t1.e2", 1'b1, 32'd0, 32'h0);
    tick(); chk_ifid("t1.e3", 1'b1, 32'd1, 32'h4);
    tick(); chk_ifid("t1.e4", 1'b1, 32'd2, 32'h8);
    check("t1.pc_f4", pc_f, 32'h10);

    // T2: stall three cycles with instr@8 in IF/ID
    stall = 1'b1; #1;
    check("t2.req_off", {31'd0, imem_req}, 32'd0);
    tick(); chk_ifid("t2.s1", 1'b1, 32'd2, 32'h8);
    check("t2.pc_hold", pc_f, 32'h10);
    tick(); chk_ifid("t2.s2", 1'b1, 32'd2, 32'h8);
    tick(); chk_ifid("t2.s3", 1'b1, 32'd2, 32'h8);
    stall = 1'b0;
    tick(); chk_ifid("t2.r1", 1'b1, 32'd3, 32'hC);
    tick(); chk_ifid("t2.r2", 1'b1, 32'd4, 32'h10);
    check("t2.pc_f", pc_f, 32'h18);

    // T3: redirect to 0x40 while 0x14 is in flight
    branch_taken = 1'b1; branch_target = 32'h40;
    tick(); chk_ifid("t3.b1", 1'b0, NOP, 32'h0);
    check("t3.pc_f", pc_f, 32'h40);
    branch_taken = 1'b0;
    tick(); chk_ifid("t3.b2", 1'b0, NOP, 32'h0);
    tick(); chk_ifid("t3.v1", 1'b1, 32'h10, 32'h40);
    tick(); chk_ifid("t3.v2", 1'b1, 32'h11, 32'h44);

    // T4: fill skid, then redirect to 0x103 while stalled
    stall = 1'b1;
    tick(); chk_ifid("t4.s", 1'b1, 32'h11, 32'h44);
    branch_taken = 1'b1; branch_target = 32'h103;
    tick(); chk_ifid("t4.b", 1'b0, NOP, 32'h0);
    check("t4.pc_f", pc_f, 32'h100);
    branch_taken = 1'b0; stall = 1'b0;
    tick(); chk_ifid("t4.bub", 1'b0, NOP, 32'h0);
    tick(); chk_ifid("t4.v", 1'b1, 32'h40, 32'h100);

    // T5: one-cycle flush drops 0x104 only
    flush_d = 1'b1;
    tick(); chk_ifid("t5.f", 1'b0, NOP, 32'h0);
    check("t5.pc_f", pc_f, 32'h10C);
    flush_d = 1'b0;
    tick(); chk_ifid("t5.v", 1'b1, 32'h42, 32'h108);

    // flush and stall together: flush wins, PC holds, nothing lands in the skid
    flush_d = 1'b1; stall = 1'b1;
    tick(); chk_ifid("fs.f", 1'b0, NOP, 32'h0);
    check("fs.pc_hold", pc_f, 32'h110);
    flush_d = 1'b0; stall = 1'b0;
    tick(); chk_ifid("fs.bub", 1'b0, NOP, 32'h0);
    tick(); chk_ifid("fs.v", 1'b1, 32'h44, 32'h110);

    // T6a: async reset in the middle of a stall, checked between edges
    stall = 1'b1;
    tick(); tick();
    #3; reset = 1'b1; #1;
    check("t6.pc_f", pc_f, 32'h0);
    check("t6.pc_d", pc_d, 32'h0);
    check("t6.req", {31'd0, imem_req}, 32'd0);
    chk_ifid("t6.rst", 1'b0, NOP, 32'h0);
    #1; reset = 1'b0; stall = 1'b0; #1;
    check("t6.req_rel", {31'd0, imem_req}, 32'd1);
    check("t6.addr_rel", imem_addr, 32'h0);
    tick(); chk_ifid("t6.bub", 1'b0, NOP, 32'h0);
    tick(); chk_ifid("t6.v", 1'b1, 32'h0, 32'h0);

    // T6b: RESET_PC near the top of the address space wraps to zero
    reset2 = 1'b0; #1;
    check("w.addr", imem_addr2, 32'hFFFF_FFF8);
    tick();
    check("w.pc_f1", pc_f2, 32'hFFFF_FFFC);
    check("w.valid0", {31'd0, valid_d2}, 32'd0);
    tick();
    check("w.pc_f2", pc_f2, 32'h0);
    check("w.pcd1", pc_d2, 32'hFFFF_FFF8);
    check("w.ins1", instr_d2, 32'h3FFF_FFFE);
    check("w.p8_1", pc_plus8_d2, 32'h0);
    tick();
    check("w.pcd2", pc_d2, 32'hFFFF_FFFC);
    check("w.p8_2", pc_plus8_d2, 32'h4);
    tick();
    check("w.pcd3", pc_d2, 32'h0);
    check("w.ins3", instr_d2, 32'h0);
    check("w.valid3", {31'd0, valid_d2}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
